// File: rtl/seq_link_pkg.sv
// seq_link_pkg: shared types and constants for the serial-sync link (transmitter and detectors).
package seq_link_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_GAP} seq_state_t;
   localparam int SEQ_SYNC_W = 4;
   localparam logic [SEQ_SYNC_W-1:0] SEQ_SYNC = 4'b1001;
   function automatic int cnt_w(int a, int b, int c);
      int m;
      m = a > b ? a : b;
      m = m > c ? m : c;
      return $clog2(m + 1);
   endfunction
endpackage

// File: rtl/seq_piso_shreg.sv
// seq_piso_shreg: parallel-load, MSB-first shift register with load/shift enables.
module seq_piso_shreg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb
);
   logic [W-1:0] sh;
   always_ff @(posedge clk)
      if (rst) sh <= '0;
      else if (load) sh <= din;
      else if (shift) sh <= sh << 1;
   assign msb = sh[W-1];
endmodule

// File: rtl/seq_frame_tx.sv
// seq_frame_tx: bit-serial frame transmitter; sync pattern, MSB-first payload, then idle gap.
module seq_frame_tx
   import seq_link_pkg::*;
#(
   parameter int                DATA_W = 8,
   parameter int                SYNC_W = SEQ_SYNC_W,
   parameter logic [SYNC_W-1:0] SYNC   = SEQ_SYNC,
   parameter int                GAP_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              dout,
   output logic              dout_valid,
   output logic              busy,
   output logic              frame_done
);
   localparam int CW = cnt_w(SYNC_W, DATA_W, GAP_W);
   localparam int GAP_LD = GAP_W > 0 ? GAP_W - 1 : 0;
   seq_state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic dout_n, dout_valid_n, frame_done_n, load, shift, sh_msb;
   assign in_ready = state == ST_IDLE;
   assign busy = !in_ready;
   assign load = in_valid && in_ready;
   assign shift = state_n == ST_DATA;
   seq_piso_shreg #(.W(DATA_W)) u_shreg (
      .clk(clk), .rst(rst), .load(load), .shift(shift), .din(in_data), .msb(sh_msb)
   );
   // cnt holds the index of the bit on the line; each phase ends when it reaches 0
   always_comb begin
      state_n = state;
      cnt_n = cnt - 1'b1;
      frame_done_n = 1'b0;
      case (state)
         ST_IDLE: begin
            state_n = load ? ST_SYNC : ST_IDLE;
            cnt_n = load ? CW'(SYNC_W - 1) : '0;
         end
         ST_SYNC: if (cnt == '0) begin
            state_n = ST_DATA;
            cnt_n = CW'(DATA_W - 1);
         end
         ST_DATA: if (cnt == '0) begin
            state_n = GAP_W > 0 ? ST_GAP : ST_IDLE;
            cnt_n = CW'(GAP_LD);
            frame_done_n = 1'b1;
         end
         ST_GAP: if (cnt == '0) begin
            state_n = ST_IDLE;
            cnt_n = '0;
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n = '0;
         end
      endcase
      dout_n = state_n == ST_SYNC ? |(SYNC & (SYNC_W'(1) << cnt_n)) : state_n == ST_DATA ? sh_msb : 1'b0;
      dout_valid_n = state_n == ST_SYNC || state_n == ST_DATA;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= ST_IDLE;
         cnt <= '0;
         dout <= 1'b0;
         dout_valid <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         dout <= dout_n;
         dout_valid <= dout_valid_n;
         frame_done <= frame_done_n;
      end
endmodule

// File: tb/tb_seq_frame_tx.sv
// tb_seq_frame_tx: directed vectors plus random traffic against a cycle-index reference model.
module tb_seq_frame_tx;
   localparam int KI = 1000;
   typedef struct {
      logic       v;
      logic [7:0] d;
      logic [3:0] e;
   } vec_t;
   logic clk = 1'b0, rst = 1'b1, va = 1'b0, vb = 1'b0, db = 1'b0;
   logic [7:0] da = 8'h00;
   logic a_rdy, a_dout, a_dv, a_busy, a_fd;
   logic b_rdy, b_dout, b_dv, b_busy, b_fd;
   int checks = 0, failures = 0, dets = 0, ka = KI, kb = KI;
   logic started = 1'b0;
   logic [7:0] wa = 8'h00;
   logic wb = 1'b0;
   logic [3:0] hist = 4'b0000;
   logic [11:0] pat = 12'b1001_1010_0101;
   vec_t tv[15];
   always #5 clk = ~clk;
   seq_frame_tx dut_a (
      .clk(clk), .rst(rst), .in_valid(va), .in_data(da), .in_ready(a_rdy),
      .dout(a_dout), .dout_valid(a_dv), .busy(a_busy), .frame_done(a_fd)
   );
   seq_frame_tx #(.DATA_W(1), .GAP_W(0)) dut_b (
      .clk(clk), .rst(rst), .in_valid(vb), .in_data(db), .in_ready(b_rdy),
      .dout(b_dout), .dout_valid(b_dv), .busy(b_busy), .frame_done(b_fd)
   );
   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // k = cycles since the accepting edge; returns {dout, dout_valid, busy, frame_done, in_ready}
   function automatic logic [4:0] expv(int k, int d, int g, logic [7:0] w);
      logic [3:0] sp;
      logic dt, dv, bs, fd;
      sp = 4'b1001;
      dv = k >= 1 && k <= 4 + d;
      dt = (k >= 1 && k <= 4) ? sp[4 - k] : (k > 4 && k <= 4 + d) ? w[4 + d - k] : 1'b0;
      bs = k >= 1 && k <= 4 + d + g;
      fd = k == 4 + d + 1;
      return {dt, dv, bs, fd, !bs};
   endfunction
   always @(posedge clk)
      if (rst) begin
         ka <= KI;
         kb <= KI;
      end else begin
         if (va && !(ka >= 1 && ka <= 14)) begin
            ka <= 1;
            wa <= da;
         end else if (ka < KI) ka <= ka + 1;
         if (vb && !(kb >= 1 && kb <= 5)) begin
            kb <= 1;
            wb <= db;
         end else if (kb < KI) kb <= kb + 1;
      end
   always @(negedge clk) begin
      hist <= {hist[2:0], a_dout};
      if ({hist[2:0], a_dout} == 4'b1001) dets <= dets + 1;
      if (started) begin
         chk("model_a", {27'd0, a_dout, a_dv, a_busy, a_fd, a_rdy}, {27'd0, expv(ka, 8, 2, wa)});
         chk("model_b", {27'd0, b_dout, b_dv, b_busy, b_fd, b_rdy}, {27'd0, expv(kb, 1, 0, {7'd0, wb})});
      end
   end
   initial begin
      int n, d0;
      logic fd_seen;
      logic [11:0] bits;
      for (int i = 0; i < 15; i++) begin
         tv[i].v = i == 0 || i == 7;
         tv[i].d = i == 7 ? 8'h3C : 8'hA5;
         tv[i].e = {i < 12 ? pat[11 - i] : 1'b0, i < 12, i == 12, i == 14};
      end
      tick();
      started = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      repeat (3) begin
         tick();
         chk("reset_idle", {27'd0, a_dout, a_dv, a_busy, a_fd, a_rdy}, 32'b00001);
      end
      for (int i = 0; i < 15; i++) begin
         va = tv[i].v;
         da = tv[i].d;
         tick();
         chk($sformatf("vec%0d", i), {28'd0, a_dout, a_dv, a_fd, a_rdy}, {28'd0, tv[i].e});
      end
      va = 1'b0;
      va = 1'b1;
      da = 8'hFF;
      tick();
      da = 8'h00;
      n = 0;
      while (!a_rdy && n < 40) begin
         tick();
         n++;
      end
      chk("b2b_period", n + 1, 15);
      tick();
      va = 1'b0;
      bits = '0;
      for (int i = 0; i < 12; i++) begin
         bits = {bits[10:0], a_dout};
         tick();
      end
      chk("b2b_bits", {20'd0, bits}, {20'd0, 12'b1001_0000_0000});
      n = 0;
      while (!a_rdy && n < 40) begin
         tick();
         n++;
      end
      va = 1'b1;
      da = 8'hA5;
      tick();
      va = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_idle", {27'd0, a_dout, a_dv, a_busy, a_fd, a_rdy}, 32'b00001);
      fd_seen = 1'b0;
      repeat (16) begin
         tick();
         fd_seen = fd_seen | a_fd;
      end
      chk("midrst_no_fd", {31'd0, fd_seen}, 32'd0);
      va = 1'b1;
      da = 8'h5A;
      tick();
      va = 1'b0;
      bits = '0;
      for (int i = 0; i < 12; i++) begin
         bits = {bits[10:0], a_dout};
         tick();
      end
      chk("after_rst_bits", {20'd0, bits}, {20'd0, 12'b1001_0101_1010});
      repeat (6) tick();
      d0 = dets;
      va = 1'b1;
      da = 8'h00;
      repeat (31) tick();
      va = 1'b0;
      repeat (20) tick();
      chk("loopback_dets", dets - d0, 3);
      n = 0;
      while (!b_rdy && n < 20) begin
         tick();
         n++;
      end
      vb = 1'b1;
      db = 1'b1;
      tick();
      n = 0;
      while (!b_rdy && n < 20) begin
         tick();
         n++;
      end
      chk("b_period", n + 1, 6);
      chk("b_fd_at_idle", {30'd0, b_fd, b_rdy}, 32'b11);
      vb = 1'b0;
      repeat (400) begin
         va = $urandom_range(0, 3) == 0;
         da = 8'($urandom);
         vb = $urandom_range(0, 2) == 0;
         db = 1'($urandom);
         rst = $urandom_range(0, 99) == 0;
         tick();
      end
      rst = 1'b0;
      va = 1'b0;
      vb = 1'b0;
      repeat (20) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
Bit-serial frame transmitter; the transmit end of the team's single-wire serial-sync link.
- Accepts one parallel payload word per frame through a valid/ready handshake.
- Emits a fixed sync pattern (default 1001), then the payload MSB-first, then a minimum idle gap.
- Sits in front of the serial line that feeds our serial sequence detectors.
- Moore-style: all line outputs are registered and depend only on state and datapath registers.

Parameters:
DATA_W  8        payload width in bits, >=1
SYNC_W  4        sync pattern length in bits, >=1
SYNC    4'b1001  sync pattern, sent MSB-first
GAP_W   2        idle zero bits forced after each frame, >=0

Ports:
clk         input   1       clock, rising edge
rst         input   1       synchronous, active-high reset
in_valid    input   1       payload word offered
in_data     input   DATA_W  payload word; sampled only on handshake
in_ready    output  1       transmitter can accept a word (high only in IDLE)
dout        output  1       serial line; idle level 0
dout_valid  output  1       high while a sync or payload bit is on dout
busy        output  1       high in SYNC, DATA and GAP
frame_done  output  1       1-cycle pulse after the last payload bit

Behaviour:
- Clock and reset: clock clk; reset rst, synchronous, active-high.
- Reset values: state IDLE, dout 0, dout_valid 0, busy 0, frame_done 0, shift register 0, bit counter 0.
- in_ready is decoded from registered state only (state==IDLE) and has no combinational path from in_valid.
- Handshake:
  - Accept when in_valid && in_ready at a rising edge N.
  - in_data is latched into the shift register, the counter is loaded, and state goes to SYNC.
  - in_valid while busy is ignored; nothing is queued.
- Timing from acceptance at edge N:
  - Cycles N+1 .. N+SYNC_W: dout = SYNC[SYNC_W-1] down to SYNC[0].
  - Cycles N+SYNC_W+1 .. N+SYNC_W+DATA_W: dout = in_data[DATA_W-1] down to in_data[0].
  - dout_valid = 1 exactly for these SYNC_W+DATA_W cycles.
  - Then GAP_W cycles of dout=0, dout_valid=0, busy=1.
  - Then IDLE with in_ready=1.
  - Minimum frame period is SYNC_W+DATA_W+GAP_W+1 cycles, including the accept cycle.
- frame_done:
  - Asserted for one cycle, in the first cycle after the last payload bit.
  - This is the first GAP cycle, or the IDLE cycle if GAP_W=0.
- State machine (IDLE, SYNC, DATA, GAP):
  - IDLE -> SYNC on handshake.
  - SYNC -> DATA when the counter reaches its last sync bit.
  - DATA -> GAP at the last payload bit, or DATA -> IDLE if GAP_W=0.
  - GAP -> IDLE when the gap counter expires.
  - Unreachable encodings recover to IDLE with outputs at reset values.
- Counter: width $clog2(max(SYNC_W,DATA_W,GAP_W)+1). It counts down and reloads on each state entry, with no wrap-around beyond the loaded value.
- Reset mid-frame: the frame is aborted. From the next cycle outputs take their reset values, the word is discarded and no frame_done is generated.
- Payload bits equal to the sync pattern are transmitted unmodified; no bit stuffing. Framing uniqueness is the receiver's concern.
- dout and dout_valid are driven from flops (glitch-free line).

Decomposition:
- Shared package seq_link_pkg holds:
  - state enum (IDLE/SYNC/DATA/GAP)
  - default SYNC value 4'b1001 and SYNC_W
  - a clog2-based counter-width function
- The same package is reused by the detector side.
- One natural sub-module: seq_piso_shreg. It is a parallel-load, MSB-first shift register with load/shift enables, instantiated for the payload.
- The sync pattern is shifted from a constant and needs no instance.

Test Plan:
1. Reset check: rst held 3 cycles, then released with in_valid=0 -> dout=0, dout_valid=0, busy=0, frame_done=0, in_ready=1 every cycle.
2. Single frame, defaults: in_data=8'hA5 accepted at edge N.
   - dout at N+1..N+12 = 1,0,0,1,1,0,1,0,0,1,0,1 with dout_valid=1.
   - frame_done=1 only at N+13; dout=0 at N+13..N+14.
   - in_ready=1 at N+15.
3. Back-to-back: in_valid held high with 8'hFF then 8'h00 -> second acceptance exactly 15 cycles after the first. in_ready is low in between. The second frame is 1,0,0,1 then eight 0s.
4. Busy ignore: in_valid pulsed with 8'h3C during the DATA phase of an 8'hA5 frame -> no acceptance, and the 8'hA5 bit stream is unchanged.
5. Reset mid-frame: rst asserted at cycle N+6 of a frame -> from N+7 all outputs are at reset values and in_ready=1. There is no frame_done, and the next accepted word transmits normally.
6. Loopback and corners: dout fed to a 1001 Moore detector.
   - One detection per frame for 8'h00; the frame is 1001 followed by zeros.
   - Rerun with GAP_W=0, DATA_W=1: frame_done coincides with the IDLE cycle, and the frame period is 6 cycles.
